// File: rtl/uart_arbiter_pkg.sv
// Shared definitions for the three-CPU UART arbiter: widths, CPU count,
// FSM state encodings and small grant-vector helpers.
package uart_arbiter_pkg;

    localparam int CpuNumWidth   = 2;
    localparam int UartDataWidth = 8;
    localparam int UartDataLengh = UartDataWidth;
    localparam int NumCpu        = 3;

    typedef enum logic [1:0] {
        UART_ARB_IDLE  = 2'd0,
        UART_ARB_BUSY  = 2'd1,
        UART_ARB_FIXED = 2'd2
    } arb_state_e;

    // CPU number to one-hot grant; 3 selects nobody.
    function automatic logic [NumCpu-1:0] cpu_onehot(input logic [CpuNumWidth-1:0] num);
        case (num)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [CpuNumWidth-1:0] ptr_after(input logic [NumCpu-1:0] gnt);
        case (gnt)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rr_pick3.sv
// Combinational round-robin picker for three requesters, starting the scan
// at ptr and wrapping modulo 3.
module uart_rr_pick3
    import uart_arbiter_pkg::*;
(
    input  logic [NumCpu-1:0]      req,
    input  logic [CpuNumWidth-1:0] ptr,
    output logic [NumCpu-1:0]      pick,
    output logic                   any_valid
);

    logic [NumCpu-1:0] rot;
    logic [NumCpu-1:0] prio;

    // Rotate so the pointer's requester sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
        prio[0] = rot[0];
        prio[1] = rot[1] & ~rot[0];
        prio[2] = rot[2] & ~rot[1] & ~rot[0];
        case (ptr)
            2'd1:    pick = {prio[1], prio[0], prio[2]};
            2'd2:    pick = {prio[0], prio[2], prio[1]};
            default: pick = prio;
        endcase
    end

    assign any_valid = |req;

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin / fixed-select arbiter sharing one UART register port between
// three J1 CPUs. Optional hold-timeout eviction: define UART_ARB_TIMEOUT_EN.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int DATA_W   = UartDataWidth,
    parameter int HOLD_MAX = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_fixed_en,
    input  logic [1:0]        cfg_fixed_num,
    input  logic              cpu0_req,
    output logic              cpu0_gnt,
    input  logic              cpu0_rd_o,
    input  logic              cpu0_wr_o,
    input  logic              cpu0_adr_o,
    input  logic [DATA_W-1:0] cpu0_dat_o,
    output logic [DATA_W-1:0] cpu0_dat_i,
    output logic              cpu0_rvalid,
    input  logic              cpu1_req,
    output logic              cpu1_gnt,
    input  logic              cpu1_rd_o,
    input  logic              cpu1_wr_o,
    input  logic              cpu1_adr_o,
    input  logic [DATA_W-1:0] cpu1_dat_o,
    output logic [DATA_W-1:0] cpu1_dat_i,
    output logic              cpu1_rvalid,
    input  logic              cpu2_req,
    output logic              cpu2_gnt,
    input  logic              cpu2_rd_o,
    input  logic              cpu2_wr_o,
    input  logic              cpu2_adr_o,
    input  logic [DATA_W-1:0] cpu2_dat_o,
    output logic [DATA_W-1:0] cpu2_dat_i,
    output logic              cpu2_rvalid,
    output logic              uart_rd,
    output logic              uart_wr,
    output logic              uart_addr,
    output logic [DATA_W-1:0] uart_din,
    input  logic [DATA_W-1:0] uart_dout
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic [NumCpu-1:0] cpu_timeout
`endif
);

    logic [NumCpu-1:0] req_v, rd_v, wr_v, adr_v;
    logic [DATA_W-1:0] dat_o_v [NumCpu];

    assign req_v      = {cpu2_req, cpu1_req, cpu0_req};
    assign rd_v       = {cpu2_rd_o, cpu1_rd_o, cpu0_rd_o};
    assign wr_v       = {cpu2_wr_o, cpu1_wr_o, cpu0_wr_o};
    assign adr_v      = {cpu2_adr_o, cpu1_adr_o, cpu0_adr_o};
    assign dat_o_v[0] = cpu0_dat_o;
    assign dat_o_v[1] = cpu1_dat_o;
    assign dat_o_v[2] = cpu2_dat_o;

    arb_state_e              state_q, state_d;
    logic [NumCpu-1:0]       gnt_q, gnt_d;
    logic [CpuNumWidth-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NumCpu-1:0]       pick_req, pick;
    logic                    any_valid;
    logic                    force_rel;
    logic                    owner_req;

    assign owner_req = |(gnt_q & req_v);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);
    logic [CNT_W-1:0]  hold_q;
    logic [NumCpu-1:0] blocked_q, tflag_q;
    logic              evict;
    logic [NumCpu-1:0] new_grant;

    assign force_rel   = (hold_q == CNT_W'(HOLD_MAX - 1));
    assign pick_req    = req_v & ~blocked_q;
    assign evict       = (state_q == UART_ARB_BUSY) & ~cfg_fixed_en & owner_req & force_rel;
    assign new_grant   = (state_q == UART_ARB_IDLE && state_d == UART_ARB_BUSY) ? gnt_d : '0;
    assign cpu_timeout = tflag_q;

    // An evicted CPU stays blocked until it is seen with req low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= '0;
            blocked_q <= '0;
            tflag_q   <= '0;
        end else begin
            if (state_q != UART_ARB_BUSY) hold_q <= '0;
            else if (!force_rel)          hold_q <= hold_q + 1'b1;
            blocked_q <= (blocked_q & req_v) | (evict ? gnt_q : '0);
            tflag_q   <= (tflag_q & ~new_grant) | (evict ? gnt_q : '0);
        end
    end
`else
    assign force_rel = 1'b0;
    assign pick_req  = req_v;
`endif

    uart_rr_pick3 u_pick (
        .req       (pick_req),
        .ptr       (rr_ptr_q),
        .pick      (pick),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= UART_ARB_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            UART_ARB_IDLE: begin
                if (cfg_fixed_en) begin
                    state_d = UART_ARB_FIXED;
                    gnt_d   = cpu_onehot(cfg_fixed_num);
                end else if (any_valid) begin
                    state_d = UART_ARB_BUSY;
                    gnt_d   = pick;
                end
            end
            UART_ARB_BUSY: begin
                if (cfg_fixed_en) begin
                    state_d = UART_ARB_FIXED;
                    gnt_d   = cpu_onehot(cfg_fixed_num);
                end else if (!owner_req || force_rel) begin
                    state_d  = UART_ARB_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = ptr_after(gnt_q);
                end
            end
            UART_ARB_FIXED: begin
                if (cfg_fixed_en) begin
                    gnt_d = cpu_onehot(cfg_fixed_num);
                end else begin
                    state_d = UART_ARB_IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = UART_ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Only the registered owner reaches the UART; a write masks a same-cycle read.
    always_comb begin
        uart_wr   = |(gnt_q & wr_v);
        uart_rd   = |(gnt_q & rd_v) & ~uart_wr;
        uart_addr = |(gnt_q & adr_v);
        uart_din  = '0;
        for (int k = 0; k < NumCpu; k++) begin
            uart_din = uart_din | (dat_o_v[k] & {DATA_W{gnt_q[k]}});
        end
    end

    logic [NumCpu-1:0] rd_tag_p1;
    logic [NumCpu-1:0] vld_p2;
    logic [DATA_W-1:0] dat_i_p2 [NumCpu];

    // p1: remember who issued the read; p2: capture uart_dout for that CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_tag_p1 <= '0;
            vld_p2    <= '0;
            for (int k = 0; k < NumCpu; k++) dat_i_p2[k] <= '0;
        end else begin
            rd_tag_p1 <= gnt_q & {NumCpu{uart_rd}};
            vld_p2    <= rd_tag_p1;
            for (int k = 0; k < NumCpu; k++) begin
                if (rd_tag_p1[k]) dat_i_p2[k] <= uart_dout;
            end
        end
    end

    assign cpu0_gnt    = gnt_q[0];
    assign cpu1_gnt    = gnt_q[1];
    assign cpu2_gnt    = gnt_q[2];
    assign cpu0_dat_i  = dat_i_p2[0];
    assign cpu1_dat_i  = dat_i_p2[1];
    assign cpu2_dat_i  = dat_i_p2[2];
    assign cpu0_rvalid = vld_p2[0];
    assign cpu1_rvalid = vld_p2[1];
    assign cpu2_rvalid = vld_p2[2];

endmodule
